// File: rtl/set3_rns_mac.sv
// Residue-domain multiply-accumulate for the {2^(n+1)-1, 2^n, 2^n-1} RNS channels.
// A two-stage pipeline (product register, then accumulate) runs under a four-state control FSM.
module set3_rns_mac #(
    parameter int unsigned n     = 5,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [n:0]       a1,
    input  logic [n:0]       w1,
    input  logic [n-1:0]     a2,
    input  logic [n-1:0]     w2,
    input  logic [n-1:0]     a3,
    input  logic [n-1:0]     w3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [n:0]       r1,
    output logic [n-1:0]     r2,
    output logic [n-1:0]     r3,
    output logic             busy
);

    localparam int unsigned K1  = n + 1;
    localparam int unsigned K3  = n;
    localparam int unsigned PW1 = 2 * K1;
    localparam int unsigned PW3 = 2 * K3;
    localparam int unsigned SW1 = K1 + 1;
    localparam int unsigned SW3 = K3 + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACC   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    // End-around carry on a (k+1)-bit sum, then map all-ones onto canonical zero.
    function automatic logic [K1-1:0] norm1(input logic [SW1-1:0] s);
        logic [K1-1:0] t;
        t = s[K1-1:0] + K1'(s[K1]);
        return (&t) ? '0 : t;
    endfunction

    function automatic logic [K3-1:0] norm3(input logic [SW3-1:0] s);
        logic [K3-1:0] t;
        t = s[K3-1:0] + K3'(s[K3]);
        return (&t) ? '0 : t;
    endfunction

    function automatic logic [K1-1:0] mul1(input logic [K1-1:0] a, input logic [K1-1:0] b);
        logic [PW1-1:0] p;
        p = PW1'(a) * PW1'(b);
        return norm1(SW1'(p[K1-1:0]) + SW1'(p[PW1-1:K1]));
    endfunction

    function automatic logic [K3-1:0] mul3(input logic [K3-1:0] a, input logic [K3-1:0] b);
        logic [PW3-1:0] p;
        p = PW3'(a) * PW3'(b);
        return norm3(SW3'(p[K3-1:0]) + SW3'(p[PW3-1:K3]));
    endfunction

    logic [1:0]       state, state_d;
    logic [LEN_W-1:0] len_q, len_d, count, count_d;
    logic             in_ready_d, out_valid_d, busy_d;
    logic             acc_clr_c, xfer_c;
    logic             p_valid;
    logic [K1-1:0]    p1;
    logic [n-1:0]     p2;
    logic [K3-1:0]    p3;

    assign xfer_c = in_valid & in_ready;

    // State and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_q     <= '0;
            count     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            len_q     <= len_d;
            count     <= count_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

    // Next-state and next-output logic; outputs are precomputed so they flop with the state.
    always_comb begin
        state_d     = state;
        len_d       = len_q;
        count_d     = count;
        in_ready_d  = in_ready;
        out_valid_d = out_valid;
        busy_d      = busy;
        acc_clr_c   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_clr_c = 1'b1;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    if (len != '0) begin
                        len_d      = len;
                        in_ready_d = 1'b1;
                        state_d    = ACC;
                    end else begin
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
            end
            ACC: begin
                if (xfer_c) begin
                    count_d = count + LEN_W'(1);
                    if (count + LEN_W'(1) == len_q) begin
                        in_ready_d = 1'b0;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // Stage 1 registers the per-channel products; stage 2 folds them into the accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            p1      <= '0;
            p2      <= '0;
            p3      <= '0;
            r1      <= '0;
            r2      <= '0;
            r3      <= '0;
        end else begin
            p_valid <= xfer_c;
            if (xfer_c) begin
                p1 <= mul1(a1, w1);
                p2 <= a2 * w2;
                p3 <= mul3(a3, w3);
            end
            if (acc_clr_c) begin
                r1 <= '0;
                r2 <= '0;
                r3 <= '0;
            end else if (p_valid) begin
                r1 <= norm1(SW1'(r1) + SW1'(p1));
                r2 <= r2 + p2;
                r3 <= norm3(SW3'(r3) + SW3'(p3));
            end
        end
    end

endmodule

// File: tb/tb_set3_rns_mac.sv
// Randomized and directed bench for set3_rns_mac; expected residues come from plain
// integer dot products reduced by % m, with literal triples pinning the directed cases.
module tb_set3_rns_mac;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] len;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] a1, w1;
    logic [4:0] a2, w2, a3, w3;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] r1;
    logic [4:0] r2, r3;
    logic       busy;

    set3_rns_mac #(.n(5), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready),
        .a1(a1), .w1(w1), .a2(a2), .w2(w2), .a3(a3), .w3(w3),
        .out_valid(out_valid), .out_ready(out_ready),
        .r1(r1), .r2(r2), .r3(r3), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [5:0] ta1[16], tw1[16];
    logic [4:0] ta2[16], tw2[16], ta3[16], tw3[16];

    int armed = 0;
    int exp_r1 = 0, exp_r2 = 0, exp_r3 = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: dot product in plain integers, reduced by each modulus.
    task automatic model(input int L);
        int s1, s2, s3;
        s1 = 0; s2 = 0; s3 = 0;
        for (int i = 0; i < L; i++) begin
            s1 += int'(ta1[i]) * int'(tw1[i]);
            s2 += int'(ta2[i]) * int'(tw2[i]);
            s3 += int'(ta3[i]) * int'(tw3[i]);
        end
        exp_r1 = s1 % 63;
        exp_r2 = s2 % 32;
        exp_r3 = s3 % 31;
    endtask

    task automatic rand_terms(input int L);
        for (int i = 0; i < L; i++) begin
            ta1[i] = 6'($urandom_range(0, 63)); tw1[i] = 6'($urandom_range(0, 63));
            ta2[i] = 5'($urandom_range(0, 31)); tw2[i] = 5'($urandom_range(0, 31));
            ta3[i] = 5'($urandom_range(0, 31)); tw3[i] = 5'($urandom_range(0, 31));
        end
    endtask

    task automatic set_term(input int i, input int x1, input int x2, input int x3,
                            input int y1, input int y2, input int y3);
        ta1[i] = 6'(x1); ta2[i] = 5'(x2); ta3[i] = 5'(x3);
        tw1[i] = 6'(y1); tw2[i] = 5'(y2); tw3[i] = 5'(y3);
    endtask

    // Result check whenever the result is presented; it must also never appear unannounced.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (armed == 0) check("unexpected_out_valid", 1, 0);
                else begin
                    check("r1", int'(r1), exp_r1);
                    check("r2", int'(r2), exp_r2);
                    check("r3", int'(r3), exp_r3);
                end
            end
            if (!busy) check("ready_when_idle", int'(in_ready), 0);
        end
    end

    // stall: 0 none, 1 toggle, 2 random; pulse: assert start mid-accumulation.
    task automatic run_dot(input int L, input int stall, input int hold, input int pulse,
                           input int use_lit, input int l1, input int l2, input int l3);
        int idx, cyc, tog, x;
        model(L);
        armed = 1;
        start = 1'b1;
        len   = 8'(L);
        step();
        start = 1'b0;
        len   = 8'($urandom_range(0, 255));
        if (L == 0) begin
            check("zl_out_valid", int'(out_valid), 1);
            check("zl_in_ready", int'(in_ready), 0);
            check("zl_r1", int'(r1), 0);
            check("zl_r2", int'(r2), 0);
            check("zl_r3", int'(r3), 0);
        end else begin
            check("start_in_ready", int'(in_ready), 1);
            check("start_busy", int'(busy), 1);
            idx = 0; cyc = 0; tog = 1;
            while (idx < L && cyc < 400) begin
                case (stall)
                    0: in_valid = 1'b1;
                    1: in_valid = tog[0];
                    default: in_valid = 1'($urandom_range(0, 1));
                endcase
                a1 = ta1[idx]; w1 = tw1[idx]; a2 = ta2[idx]; w2 = tw2[idx];
                a3 = ta3[idx]; w3 = tw3[idx];
                if (pulse != 0 && cyc == 0) begin
                    start = 1'b1;
                    len   = 8'd0;
                end
                #3;
                x = (in_valid && in_ready) ? 1 : 0;
                step();
                start = 1'b0;
                idx += x;
                tog ^= 1;
                cyc++;
            end
            if (cyc >= 400) check("acc_timeout", idx, L);
            in_valid = 1'($urandom_range(0, 1));
            a1 = 6'($urandom); a2 = 5'($urandom); a3 = 5'($urandom);
            check("drain_out_valid", int'(out_valid), 0);
            check("drain_in_ready", int'(in_ready), 0);
            check("drain_busy", int'(busy), 1);
            step();
            check("result_out_valid", int'(out_valid), 1);
        end
        if (use_lit != 0) begin
            check("lit_r1", int'(r1), l1);
            check("lit_r2", int'(r2), l2);
            check("lit_r3", int'(r3), l3);
        end
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            start    = 1'($urandom_range(0, 1));
            step();
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_in_ready", int'(in_ready), 0);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        armed     = 0;
        check("post_out_valid", int'(out_valid), 0);
        check("post_busy", int'(busy), 0);
        check("post_in_ready", int'(in_ready), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; out_ready = 1'b0;
        a1 = '0; w1 = '0; a2 = '0; w2 = '0; a3 = '0; w3 = '0;
        repeat (3) step();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_r1", int'(r1), 0);
        check("rst_r2", int'(r2), 0);
        check("rst_r3", int'(r3), 0);
        @(negedge clk) rst_n = 1'b1;
        step();

        set_term(0, 10, 7, 4, 3, 5, 8);
        run_dot(1, 0, 0, 0, 1, 30, 3, 1);

        set_term(0, 63, 2, 31, 5, 3, 9);
        run_dot(1, 0, 2, 0, 1, 0, 6, 0);

        for (int i = 0; i < 3; i++) set_term(i, 62, 31, 30, 62, 31, 30);
        run_dot(3, 0, 1, 0, 1, 3, 3, 3);

        rand_terms(4);
        run_dot(4, 1, 5, 0, 0, 0, 0, 0);

        run_dot(0, 0, 1, 0, 1, 0, 0, 0);

        rand_terms(2);
        run_dot(2, 0, 0, 1, 0, 0, 0, 0);

        // Reset after two of five terms: nothing partial may surface.
        rand_terms(5);
        armed = 0;
        start = 1'b1; len = 8'd5;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            a1 = ta1[i]; w1 = tw1[i]; a2 = ta2[i]; w2 = tw2[i]; a3 = ta3[i]; w3 = tw3[i];
            step();
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", int'(in_ready), 0);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_r1", int'(r1), 0);
        check("mid_rst_r2", int'(r2), 0);
        check("mid_rst_r3", int'(r3), 0);
        in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step();
        set_term(0, 1, 1, 1, 1, 1, 1);
        run_dot(1, 0, 0, 0, 1, 1, 1, 1);

        for (int k = 0; k < 10; k++) begin
            int L;
            L = $urandom_range(1, 12);
            rand_terms(L);
            run_dot(L, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 1), 0, 0, 0, 0);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
